// File: rtl/imm_ext_queue_if.sv
// Handshake bundle for the immediate-extension queue: producer side, consumer side,
// flush and occupancy.
interface imm_ext_queue_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_imm;
    logic [TAG_W-1:0] out_tag;
    logic [CW-1:0]    count;

    modport master (
        output flush, in_valid, in_imm, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, count
    );

    modport slave (
        input  flush, in_valid, in_imm, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, count
    );
endinterface

// File: rtl/imm_ext_queue.sv
// Buffered immediate-extension stage: extends raw immediates at push time and
// queues them with their tag in a small FIFO with valid/ready on both sides.
module imm_ext_queue #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    imm_ext_queue_if.slave q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] OP_ZERO      = 2'b00;
    localparam logic [1:0] OP_SIGN      = 2'b01;
    localparam logic [1:0] OP_LUI       = 2'b10;
    localparam logic [1:0] OP_SIGN_SHL2 = 2'b11;

    logic [OUT_W-1:0] mem_imm [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count_r;
    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] ext_imm;
    logic             push;
    logic             pop;

    always_comb begin
        sign_ext = {{(OUT_W-IN_W){q.in_imm[IN_W-1]}}, q.in_imm};
        ext_imm  = '0;
        case (q.in_op)
            OP_ZERO:      ext_imm = {{(OUT_W-IN_W){1'b0}}, q.in_imm};
            OP_SIGN:      ext_imm = sign_ext;
            OP_LUI:       ext_imm = {q.in_imm, {(OUT_W-IN_W){1'b0}}};
            OP_SIGN_SHL2: ext_imm = sign_ext << 2;
            default:      ext_imm = '0;
        endcase
    end

    // Readiness looks only at the registered count, so a full queue cannot
    // accept in the same cycle it is being popped.
    assign q.in_ready  = !reset && (count_r < CW'(DEPTH));
    assign q.out_valid = (count_r != '0);
    assign q.out_imm   = q.out_valid ? mem_imm[rd_ptr] : '0;
    assign q.out_tag   = q.out_valid ? mem_tag[rd_ptr] : '0;
    assign q.count     = count_r;

    assign push = q.in_valid && q.in_ready;
    assign pop  = q.out_valid && q.out_ready;

    // Storage has no reset; only pointers and count qualify its contents.
    always_ff @(posedge clk) begin
        if (push && !q.flush) begin
            mem_imm[wr_ptr] <= ext_imm;
            mem_tag[wr_ptr] <= q.in_tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_r <= '0;
        end else if (q.flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: tb/tb_imm_ext_queue.sv
// Directed bench for imm_ext_queue with a queue-based reference model checked
// every falling edge, plus literal expectations for the key scenarios.
module tb_imm_ext_queue;
    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int TAG_W = 5;
    localparam int DEPTH = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    imm_ext_queue_if #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) q ();

    imm_ext_queue #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (q)
    );

    always #5 clk = ~clk;

    logic [TAG_W+OUT_W-1:0] mq[$];
    logic [OUT_W-1:0]       mode_lit [4];

    function automatic logic [OUT_W-1:0] ext_model(input logic [IN_W-1:0] imm, input logic [1:0] op);
        longint s;
        longint u;
        u = longint'(imm);
        s = (u >= 32768) ? u - 65536 : u;
        case (op)
            2'd0:    return OUT_W'(u);
            2'd1:    return OUT_W'(s);
            2'd2:    return OUT_W'(u * 65536);
            default: return OUT_W'(s * 4);
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
        end else begin
            logic do_push;
            logic do_pop;
            do_push = q.in_valid && (mq.size() < DEPTH);
            do_pop  = q.out_ready && (mq.size() > 0);
            if (q.flush) begin
                mq.delete();
            end else begin
                if (do_pop)
                    void'(mq.pop_front());
                if (do_push)
                    mq.push_back({q.in_tag, ext_model(q.in_imm, q.in_op)});
            end
        end
    end

    always @(negedge clk) begin
        logic [TAG_W+OUT_W-1:0] head;
        head = (mq.size() > 0) ? mq[0] : '0;
        check("m_in_ready",  64'(q.in_ready),  64'(!reset && (mq.size() < DEPTH)));
        check("m_out_valid", 64'(q.out_valid), 64'(mq.size() != 0));
        check("m_count",     64'(q.count),     64'(mq.size()));
        check("m_out_imm",   64'(q.out_imm),   64'(head[OUT_W-1:0]));
        check("m_out_tag",   64'(q.out_tag),   64'(head[TAG_W+OUT_W-1:OUT_W]));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        mode_lit[0] = 32'h00008001;
        mode_lit[1] = 32'hFFFF8001;
        mode_lit[2] = 32'h80010000;
        mode_lit[3] = 32'hFFFE0004;

        q.flush     = 1'b0;
        q.in_valid  = 1'b0;
        q.in_imm    = '0;
        q.in_op     = '0;
        q.in_tag    = '0;
        q.out_ready = 1'b0;

        step();
        check("rst_in_ready",  64'(q.in_ready),  64'd0);
        check("rst_out_valid", 64'(q.out_valid), 64'd0);
        check("rst_count",     64'(q.count),     64'd0);
        check("rst_out_imm",   64'(q.out_imm),   64'd0);
        step();
        reset = 1'b0;
        step();

        // each extension mode on 16'h8001
        for (int op = 0; op < 4; op++) begin
            q.in_valid = 1'b1;
            q.in_imm   = 16'h8001;
            q.in_op    = 2'(op);
            q.in_tag   = TAG_W'(op);
            step();
            q.in_valid = 1'b0;
            check("mode_imm",   64'(q.out_imm),   64'(mode_lit[op]));
            check("mode_valid", 64'(q.out_valid), 64'd1);
            q.out_ready = 1'b1;
            step();
            q.out_ready = 1'b0;
        end

        // fill to full with consumer stalled
        q.in_valid = 1'b1;
        q.in_op    = 2'd1;
        for (int t = 1; t <= 3; t++) begin
            q.in_imm = 16'(16'h0100 + t);
            q.in_tag = TAG_W'(t);
            if (t < 3)
                step();
        end
        check("full_count",    64'(q.count),    64'd2);
        check("full_in_ready", 64'(q.in_ready), 64'd0);
        step();
        step();
        check("full_head_tag", 64'(q.out_tag), 64'd1);
        check("full_count2",   64'(q.count),   64'd2);

        // full + pop: pop only, push of tag 3 lands one cycle later
        q.out_ready = 1'b1;
        step();
        check("fp_count", 64'(q.count),   64'd1);
        check("fp_head",  64'(q.out_tag), 64'd2);
        step();
        check("fp_count2", 64'(q.count),   64'd1);
        check("fp_head2",  64'(q.out_tag), 64'd3);
        q.in_valid = 1'b0;
        step();
        check("fp_empty", 64'(q.out_valid), 64'd0);

        // streaming tags 0..7
        q.in_valid  = 1'b1;
        q.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            q.in_imm = 16'(16'h7FF0 + 16'(i * 3));
            q.in_op  = 2'(i);
            q.in_tag = TAG_W'(i);
            step();
            check("str_tag",   64'(q.out_tag), 64'(i));
            check("str_count", 64'(q.count),   64'd1);
        end
        q.in_valid = 1'b0;
        step();
        check("str_drain", 64'(q.count), 64'd0);

        // flush discards queued entry and concurrent push
        q.out_ready = 1'b0;
        q.in_valid  = 1'b1;
        q.in_imm    = 16'hABCD;
        q.in_op     = 2'd0;
        q.in_tag    = 5'd9;
        step();
        check("fl_pre_count", 64'(q.count), 64'd1);
        q.flush  = 1'b1;
        q.in_tag = 5'd10;
        step();
        q.flush    = 1'b0;
        q.in_valid = 1'b0;
        check("fl_count", 64'(q.count),     64'd0);
        check("fl_valid", 64'(q.out_valid), 64'd0);
        step();
        check("fl_never", 64'(q.out_valid), 64'd0);

        // async reset between edges with two entries held
        q.in_valid = 1'b1;
        q.in_tag   = 5'd11;
        step();
        q.in_tag = 5'd12;
        step();
        q.in_valid = 1'b0;
        check("ar_pre_count", 64'(q.count), 64'd2);
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid",    64'(q.out_valid), 64'd0);
        check("ar_count",    64'(q.count),     64'd0);
        check("ar_in_ready", 64'(q.in_ready),  64'd0);
        step();
        reset = 1'b0;
        q.in_valid = 1'b1;
        q.in_imm   = 16'h0004;
        q.in_op    = 2'd3;
        q.in_tag   = 5'd20;
        step();
        q.in_valid = 1'b0;
        check("ar_resume_tag", 64'(q.out_tag), 64'd20);
        check("ar_resume_imm", 64'(q.out_imm), 64'h00000010);
        q.out_ready = 1'b1;
        step();
        check("ar_resume_empty", 64'(q.count), 64'd0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
